// File: rtl/kf_dma_priority_arbiter.sv
// kf_dma_priority_arbiter
// DMA request arbiter for the KF8237 successor. It holds the mask, software-request
// and command state and conditions the raw DREQ lines (polarity, edge or level).
// It resolves fixed or rotating priority into a registered one-hot grant. The grant
// holds while the timing FSM acknowledges a channel.
// Optional build macro: KF_DMA_ARB_STATUS_EN adds a terminal-count status register
// with its read strobe.
module kf_dma_priority_arbiter #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_command_register,
    input  logic                write_request_register,
    input  logic                set_or_reset_mask_register,
    input  logic                write_mask_register,
    input  logic                master_clear,
    input  logic                clear_mask_register,
    input  logic [CHANNELS-1:0] edge_request,
    input  logic [CHANNELS-1:0] dma_request,
    input  logic [CHANNELS-1:0] dma_acknowledge_internal,
    input  logic                end_of_process,
`ifdef KF_DMA_ARB_STATUS_EN
    input  logic                read_status_register,
    output logic [7:0]          status_register,
`endif
    output logic [CHANNELS-1:0] encoded_dma,
    output logic [IDX_W-1:0]    rotate_pointer
);

    localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);
    localparam logic [IDX_W-1:0]    LAST_CH  = IDX_W'(CHANNELS - 1);

    logic [7:0]          cmd_q, cmd_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] req_q, req_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    rot_q, rot_d;

    logic                ctrl_disable;
    logic                rotating;
    logic                active_low;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] hw_pending;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] eop_clr;
    logic [CHANNELS-1:0] winner;
    logic                ack_any;
    logic [IDX_W-1:0]    ack_idx;
    logic [IDX_W-1:0]    search_base;
    logic [IDX_W-1:0]    idx;
    logic                unused_cmd;

    assign ctrl_disable = cmd_q[2];
    assign rotating     = cmd_q[4];
    assign active_low   = cmd_q[6];
    // The remaining command bits are kept for readback compatibility only.
    assign unused_cmd   = ^{cmd_q[7], cmd_q[5], cmd_q[3], cmd_q[1:0]};

    // DREQ conditioning: polarity, then edge detect against last cycle's level.
    // A fresh edge counts as pending in the same cycle it is seen, so edge and
    // level channels both reach the grant one cycle after the request.
    assign level      = dma_request ^ {CHANNELS{active_low}};
    assign rise       = level & ~prev_q;
    assign hw_pending = (edge_request & (edge_q | rise)) | (~edge_request & level);
    assign pending    = (hw_pending & ~mask_q) | req_q;

    assign wr_sel  = ONE_HOT0 << internal_data_bus[IDX_W-1:0];
    assign eop_clr = end_of_process ? dma_acknowledge_internal : '0;
    assign ack_any = |dma_acknowledge_internal;

    // Rotating search starts just after the last serviced channel; fixed starts at 0.
    // CHANNELS is a power of two, so index arithmetic wraps naturally.
    assign search_base = rotating ? (rot_q + IDX_W'(1)) : '0;

    // Priority search: walk from the lowest priority down so the highest-priority
    // pending channel is the last one written.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = search_base + IDX_W'(i);
            if (pending[idx]) begin
                winner = ONE_HOT0 << idx;
            end
        end
    end

    // Lowest set acknowledge bit names the serviced channel (multi-hot is illegal).
    always_comb begin
        ack_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (dma_acknowledge_internal[i]) begin
                ack_idx = IDX_W'(i);
            end
        end
    end

    // Next-state for all configuration, conditioning and grant state.
    always_comb begin
        cmd_d   = cmd_q;
        mask_d  = mask_q;
        req_d   = req_q;
        edge_d  = edge_q;
        prev_d  = level;
        rot_d   = rot_q;
        grant_d = grant_q;

        if (write_command_register) begin
            cmd_d = internal_data_bus;
        end

        if (clear_mask_register) begin
            mask_d = '0;
        end else if (write_mask_register) begin
            mask_d = internal_data_bus[CHANNELS-1:0];
        end else if (set_or_reset_mask_register) begin
            mask_d = internal_data_bus[IDX_W] ? (mask_q | wr_sel) : (mask_q & ~wr_sel);
        end

        // Terminal-count clear first, so a same-cycle software write wins.
        req_d = req_q & ~eop_clr;
        if (write_request_register) begin
            req_d = internal_data_bus[IDX_W] ? (req_d | wr_sel) : (req_d & ~wr_sel);
        end

        // Acknowledge consumes the latched edge, even if a new edge arrives with it.
        edge_d = (edge_q | (rise & edge_request)) & ~dma_acknowledge_internal;

        if (ack_any) begin
            rot_d = ack_idx;
        end

        if (ctrl_disable) begin
            grant_d = '0;
        end else if (ack_any) begin
            grant_d = grant_q;
        end else begin
            grant_d = winner;
        end

        if (master_clear) begin
            cmd_d   = '0;
            mask_d  = '1;
            req_d   = '0;
            edge_d  = '0;
            prev_d  = '0;
            rot_d   = LAST_CH;
            grant_d = '0;
        end
    end

    // State registers with asynchronous reset to the power-on configuration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            mask_q  <= '1;
            req_q   <= '0;
            edge_q  <= '0;
            prev_q  <= '0;
            rot_q   <= LAST_CH;
            grant_q <= '0;
        end else begin
            cmd_q   <= cmd_d;
            mask_q  <= mask_d;
            req_q   <= req_d;
            edge_q  <= edge_d;
            prev_q  <= prev_d;
            rot_q   <= rot_d;
            grant_q <= grant_d;
        end
    end

    assign encoded_dma    = grant_q;
    assign rotate_pointer = rot_q;

`ifdef KF_DMA_ARB_STATUS_EN
    logic [CHANNELS-1:0] tc_q, tc_d;

    // Terminal-count flags: a read clears them, a same-cycle EOP sets them again.
    always_comb begin
        tc_d = (tc_q & ~{CHANNELS{read_status_register}}) | eop_clr;
        if (master_clear) begin
            tc_d = '0;
        end
    end

    // Terminal-count flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tc_q <= '0;
        end else begin
            tc_q <= tc_d;
        end
    end

    if (CHANNELS <= 4) begin : g_status_small
        assign status_register = {4'(pending), 4'(tc_q)};
    end else begin : g_status_wide
        assign status_register = 8'(tc_q);
    end
`endif

endmodule

// File: tb/tb_kf_dma_priority_arbiter.sv
`timescale 1ns/1ps
// Bench for kf_dma_priority_arbiter (CHANNELS=4): directed sequences with literal
// expectations, then randomized traffic compared every cycle with a behavioural model.
module tb_kf_dma_priority_arbiter;

    localparam int C = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   internal_data_bus;
    logic         write_command_register;
    logic         write_request_register;
    logic         set_or_reset_mask_register;
    logic         write_mask_register;
    logic         master_clear;
    logic         clear_mask_register;
    logic [C-1:0] edge_request;
    logic [C-1:0] dma_request;
    logic [C-1:0] dma_acknowledge_internal;
    logic         end_of_process;
    logic [C-1:0] encoded_dma;
    logic [1:0]   rotate_pointer;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    kf_dma_priority_arbiter #(.CHANNELS(C)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .internal_data_bus          (internal_data_bus),
        .write_command_register     (write_command_register),
        .write_request_register     (write_request_register),
        .set_or_reset_mask_register (set_or_reset_mask_register),
        .write_mask_register        (write_mask_register),
        .master_clear               (master_clear),
        .clear_mask_register        (clear_mask_register),
        .edge_request               (edge_request),
        .dma_request                (dma_request),
        .dma_acknowledge_internal   (dma_acknowledge_internal),
        .end_of_process             (end_of_process),
        .encoded_dma                (encoded_dma),
        .rotate_pointer             (rotate_pointer)
    );

    // ---------------- behavioural model ----------------
    bit       m_mask[C];
    bit       m_req[C];
    bit       m_edge[C];
    bit       m_prev[C];
    bit [7:0] m_cmd;
    int       m_rot;
    int       m_grant;   // granted channel number, -1 = none

    task automatic model_reset();
        for (int k = 0; k < C; k++) begin
            m_mask[k] = 1'b1;
            m_req[k]  = 1'b0;
            m_edge[k] = 1'b0;
            m_prev[k] = 1'b0;
        end
        m_cmd   = 8'h00;
        m_rot   = C - 1;
        m_grant = -1;
    endtask

    task automatic model_step();
        bit lvl[C];
        bit pend[C];
        bit edge_n[C];
        bit req_n[C];
        bit mask_n[C];
        int ack_ch;
        int nxt;
        int ch;
        int sel;
        bit setv;
        if (master_clear) begin
            model_reset();
            return;
        end
        ack_ch = -1;
        for (int k = C - 1; k >= 0; k--)
            if (dma_acknowledge_internal[k]) ack_ch = k;
        for (int k = 0; k < C; k++) begin
            lvl[k] = (dma_request[k] != m_cmd[6]);
            if (edge_request[k]) pend[k] = m_edge[k] || (lvl[k] && !m_prev[k]);
            else                 pend[k] = lvl[k];
            pend[k] = (pend[k] && !m_mask[k]) || m_req[k];
        end
        if (m_cmd[2]) nxt = -1;
        else if (ack_ch >= 0) nxt = m_grant;
        else begin
            nxt = -1;
            for (int n = 0; n < C; n++) begin
                ch = m_cmd[4] ? (m_rot + 1 + n) % C : n;
                if (nxt < 0 && pend[ch]) nxt = ch;
            end
        end
        for (int k = 0; k < C; k++) begin
            if (dma_acknowledge_internal[k]) edge_n[k] = 1'b0;
            else edge_n[k] = m_edge[k] || (edge_request[k] && lvl[k] && !m_prev[k]);
            req_n[k]  = (end_of_process && dma_acknowledge_internal[k]) ? 1'b0 : m_req[k];
            mask_n[k] = m_mask[k];
        end
        sel  = int'(internal_data_bus[1:0]);
        setv = internal_data_bus[2];
        if (write_request_register) req_n[sel] = setv;
        if (clear_mask_register) begin
            for (int k = 0; k < C; k++) mask_n[k] = 1'b0;
        end else if (write_mask_register) begin
            for (int k = 0; k < C; k++) mask_n[k] = internal_data_bus[k];
        end else if (set_or_reset_mask_register) begin
            mask_n[sel] = setv;
        end
        for (int k = 0; k < C; k++) begin
            m_edge[k] = edge_n[k];
            m_req[k]  = req_n[k];
            m_mask[k] = mask_n[k];
            m_prev[k] = lvl[k];
        end
        if (ack_ch >= 0) m_rot = ack_ch;
        if (write_command_register) m_cmd = internal_data_bus;
        m_grant = nxt;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [C-1:0] exp_g;
        if (chk_en) begin
            exp_g = (m_grant < 0) ? '0 : (C'(1) << m_grant);
            n_total++;
            if (encoded_dma === exp_g) n_pass++;
            else $display("FAIL model_grant t=%0t dut=%b model=%b", $time, encoded_dma, exp_g);
            n_total++;
            if (rotate_pointer === 2'(m_rot)) n_pass++;
            else $display("FAIL model_rotptr t=%0t dut=%0d model=%0d", $time, rotate_pointer, m_rot);
        end
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe_cmd(input logic [7:0] d);
        internal_data_bus      = d;
        write_command_register = 1'b1;
        tick();
        write_command_register = 1'b0;
    endtask

    task automatic ack_pulse(input logic [C-1:0] a, input bit eop);
        dma_acknowledge_internal = a;
        end_of_process           = eop;
        tick();
        dma_acknowledge_internal = '0;
        end_of_process           = 1'b0;
    endtask

    initial begin
        reset_n                    = 1'b0;
        internal_data_bus          = '0;
        write_command_register     = 1'b0;
        write_request_register     = 1'b0;
        set_or_reset_mask_register = 1'b0;
        write_mask_register        = 1'b0;
        master_clear               = 1'b0;
        clear_mask_register        = 1'b0;
        edge_request               = '0;
        dma_request                = 4'b1111;
        dma_acknowledge_internal   = '0;
        end_of_process             = 1'b0;
        tick(3);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset: everything masked.
        tick(2);
        lit("reset_masked", 8'(encoded_dma), 8'b0000);
        lit("reset_rotptr", 8'(rotate_pointer), 8'd3);

        // Clear mask -> grant one cycle after the mask takes effect.
        clear_mask_register = 1'b1;
        tick();
        clear_mask_register = 1'b0;
        lit("clrmask_lag", 8'(encoded_dma), 8'b0000);
        tick();
        lit("clrmask_grant", 8'(encoded_dma), 8'b0001);

        // Fixed priority stepping.
        dma_request = 4'b1110; tick(); lit("fixed_1110", 8'(encoded_dma), 8'b0010);
        dma_request = 4'b1100; tick(); lit("fixed_1100", 8'(encoded_dma), 8'b0100);
        dma_request = 4'b1000; tick(); lit("fixed_1000", 8'(encoded_dma), 8'b1000);

        // Rotating priority.
        dma_request = 4'b1111;
        strobe_cmd(8'h10);
        tick();
        lit("rot_start", 8'(encoded_dma), 8'b0001);
        ack_pulse(4'b0010, 1'b0);
        lit("rot_ptr1", 8'(rotate_pointer), 8'd1);
        lit("rot_hold", 8'(encoded_dma), 8'b0001);
        tick();
        lit("rot_after1", 8'(encoded_dma), 8'b0100);
        ack_pulse(4'b0100, 1'b0);
        lit("rot_ptr2", 8'(rotate_pointer), 8'd2);
        tick();
        lit("rot_after2", 8'(encoded_dma), 8'b1000);
        ack_pulse(4'b1000, 1'b0);
        lit("rot_ptr3", 8'(rotate_pointer), 8'd3);
        tick();
        lit("rot_wrap", 8'(encoded_dma), 8'b0001);

        // Active-low DREQ, then controller disable.
        strobe_cmd(8'h40);
        tick();
        lit("actlow_1111", 8'(encoded_dma), 8'b0000);
        dma_request = 4'b0111;
        tick();
        lit("actlow_0111", 8'(encoded_dma), 8'b1000);
        strobe_cmd(8'h04);
        tick();
        lit("disable", 8'(encoded_dma), 8'b0000);

        // Software request bypasses the mask, auto-cleared by EOP.
        internal_data_bus   = 8'h0F;
        write_mask_register = 1'b1;
        tick();
        write_mask_register = 1'b0;
        dma_request = 4'b0000;
        strobe_cmd(8'h00);
        tick();
        internal_data_bus      = 8'h07;
        write_request_register = 1'b1;
        tick();
        write_request_register = 1'b0;
        tick();
        lit("swreq_grant", 8'(encoded_dma), 8'b1000);
        ack_pulse(4'b1000, 1'b1);
        lit("swreq_hold", 8'(encoded_dma), 8'b1000);
        tick();
        lit("swreq_cleared", 8'(encoded_dma), 8'b0000);

        // Edge-triggered channel 0.
        clear_mask_register = 1'b1;
        tick();
        clear_mask_register = 1'b0;
        edge_request = 4'b0001;
        tick();
        dma_request = 4'b0001;
        tick();
        lit("edge_first", 8'(encoded_dma), 8'b0001);
        tick();
        ack_pulse(4'b0001, 1'b0);
        tick();
        lit("edge_no_regrant", 8'(encoded_dma), 8'b0000);
        tick(2);
        lit("edge_still_none", 8'(encoded_dma), 8'b0000);
        dma_request = 4'b0000;
        tick();
        dma_request = 4'b0001;
        tick();
        lit("edge_regrant", 8'(encoded_dma), 8'b0001);

        // Same with level-triggered channel 0.
        edge_request = 4'b0000;
        tick();
        ack_pulse(4'b0001, 1'b0);
        tick();
        lit("level_regrant", 8'(encoded_dma), 8'b0001);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            internal_data_bus = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 80) internal_data_bus[2] = 1'b0;
            write_command_register     = ($urandom_range(0, 99) < 4);
            if (write_command_register && $urandom_range(0, 99) < 85)
                internal_data_bus[2] = 1'b0;
            write_request_register     = ($urandom_range(0, 99) < 6);
            set_or_reset_mask_register = ($urandom_range(0, 99) < 6);
            write_mask_register        = ($urandom_range(0, 99) < 3);
            clear_mask_register        = ($urandom_range(0, 99) < 3);
            master_clear               = ($urandom_range(0, 999) < 4);
            if ($urandom_range(0, 99) < 30) dma_request = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 2)  edge_request = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 30) begin
                dma_acknowledge_internal = 4'b0001 << $urandom_range(0, C - 1);
                end_of_process           = ($urandom_range(0, 99) < 40);
            end else begin
                dma_acknowledge_internal = '0;
                end_of_process           = ($urandom_range(0, 99) < 5);
            end
            tick();
        end
        write_command_register     = 1'b0;
        write_request_register     = 1'b0;
        set_or_reset_mask_register = 1'b0;
        write_mask_register        = 1'b0;
        clear_mask_register        = 1'b0;
        master_clear               = 1'b0;
        dma_acknowledge_internal   = '0;
        end_of_process             = 1'b0;
        tick(2);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kf_dma_priority_arbiter.md
Name: kf_dma_priority_arbiter

Overview:
Parametrised DMA request arbiter, successor to the fixed 4-channel KF8237 priority encoder. It holds the mask, software-request and command-mode state, and conditions raw DREQ lines (polarity, edge/level). It tracks rotating priority internally from observed acknowledges and issues a registered one-hot grant to the DMA timing/control FSM. It sits between the KF8237 bus-interface register decode and the DMA timing FSM.

Parameters:
CHANNELS, 4, number of DMA channels; legal values 2, 4, 8.
IDX_W, $clog2(CHANNELS), channel index width (derived; not overridden).

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset_n  in  1  asynchronous active-low reset
internal_data_bus  in  8  write data from bus interface
write_command_register  in  1  command write strobe, one cycle
write_request_register  in  1  single-channel software request set/clear strobe
set_or_reset_mask_register  in  1  single-channel mask set/clear strobe
write_mask_register  in  1  write all mask bits strobe
master_clear  in  1  synchronous soft reset strobe
clear_mask_register  in  1  clear all mask bits strobe
edge_request  in  CHANNELS  per-channel 1=edge-triggered DREQ, 0=level
dma_request  in  CHANNELS  raw DREQ lines
dma_acknowledge_internal  in  CHANNELS  one-hot active-channel ack from timing FSM
end_of_process  in  1  terminal count / EOP for the acked channel
encoded_dma  out  CHANNELS  registered one-hot grant; 0 = none
rotate_pointer  out  IDX_W  last serviced channel (debug/status)

Behaviour:
- Reset (reset_n low, async) and master_clear (sync, one cycle): mask = all 1s; request register = 0; command = 0; edge latches = 0; previous-DREQ register = 0; rotate_pointer = CHANNELS-1; encoded_dma = 0.
- Command register: bit2 = controller disable, bit4 = rotating priority, bit6 = DREQ active-low; other bits stored, unused here.
- Mask: set_or_reset_mask_register: bit IDX_W of data = set(1)/clear(0); data[IDX_W-1:0] = channel. write_mask_register: mask = data[CHANNELS-1:0]. clear_mask_register: mask = 0. Multiple strobes in one cycle: priority clear_mask_register > write_mask_register > set_or_reset.
- Software request: write_request_register uses the same encoding (bit IDX_W = set, low bits = channel). Auto-clear: end_of_process with dma_acknowledge_internal[k]=1 clears request bit k. The same cycle's write to channel k is applied after the clear, so the write wins.
- DREQ conditioning: level = dma_request XOR {CHANNELS{cmd[6]}}. Edge channel k: latch sets when level[k]=1 and prev[k]=0; clears when ack[k]=1 (ack wins over a simultaneous new edge). Level channel: pending = level[k].
- pending = (hw_pending & ~mask) | request_register. Software requests bypass the mask.
- Arbitration, 1-cycle latency: encoded_dma next-state = one-hot winner of pending.
  - Fixed priority (cmd[4]=0): lowest index wins.
  - Rotating priority (cmd[4]=1): search starts at rotate_pointer+1 mod CHANNELS and wraps.
  - cmd[2]=1 or pending=0: encoded_dma = 0 next cycle.
- Grant hold: while dma_acknowledge_internal != 0, encoded_dma is frozen and pending changes are ignored. Re-arbitration resumes the cycle after ack drops to 0. Controller disable overrides hold and forces 0.
- Rotation update: any cycle with ack[k]=1 sets rotate_pointer = k. Multi-hot ack is illegal; the lowest set index is taken.
- A command write changes mode from the next cycle. The pointer is not reset by a mode change.

Optional Feature:
KF_DMA_ARB_STATUS_EN — when defined, adds input read_status_register (1) and output status_register (8). Status bits [CHANNELS-1:0]: terminal-count flags, set by end_of_process with ack[k]. For CHANNELS≤4, bits [7:4] = pending[3:0]. Flags clear in the cycle after a read_status_register pulse; a simultaneous set wins. When not defined: no ports, no TC state, all other behaviour identical.

Test Plan:
Reset, CHANNELS=4, dma_request=1111, no writes -> encoded_dma=0000 (all masked). clear_mask_register -> encoded_dma=0001 one cycle later.
Mask cleared, dma_request 1111→1110→1100→1000 per cycle, fixed priority -> encoded_dma 0001,0010,0100,1000, each lagging one cycle.
Command 0x10, dma_request=1111, ack pulse on channel 1 -> rotate_pointer=1; after ack drops, encoded_dma=0100. Then ack ch2 -> next grant 1000; ack ch3 -> 0001 (wrap).
Command 0x40, dma_request=1111 -> encoded_dma=0000. dma_request=0111 -> 1000. Command 0x04 -> encoded_dma=0000 within one cycle despite pending.
write_request_register data=0x07 with all masked -> encoded_dma=1000. end_of_process+ack=1000 -> request cleared, encoded_dma=0000 after ack drops.
edge_request=0001, dma_request held at 0001, ack pulse -> no re-grant while level stays high. Drop to 0 then raise -> grant 0001 again. Same sequence with edge_request=0000 -> regranted immediately after ack drops.
